// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath widths, default reset PC and the
// fetch queue entry layout used by the fetch front end.
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One prefetch queue slot: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO for the fetch prefetch queue.
// Flush has priority over push and pop. The head is read combinationally from
// the registered storage, so a pushed entry becomes visible one cycle later.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  fetch_entry_t           i_data,
  output fetch_entry_t           o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  // A full queue may still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write port; contents need no reset because count guards validity.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential fetch address generation, credit
// limited request issue to a variable-latency instruction memory, an in-order
// prefetch queue toward decode, and redirect handling that discards any
// responses still in flight from the old stream.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop;

  logic [CNT_W-1:0] w_outstanding_next;
  logic [CNT_W-1:0] w_drop_next;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W:0]   w_inflight;
  logic             w_credit;
  logic             w_req_fire;
  logic             w_push;
  logic             w_pop;
  logic             w_stale;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [XLEN-1:0]  w_redirect_pc;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  // Queued plus outstanding never exceeds DEPTH, so every response has a slot.
  assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit       = (w_inflight < (CNT_W + 1)'(DEPTH));

  // Requests are held off while reset is asserted and during a redirect cycle.
  assign imem_req_valid = rst && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};

  // A response is stale if it belongs to a stream a redirect has abandoned.
  assign w_stale        = imem_rsp_valid && (redirect_valid || (r_drop != '0));
  assign w_push         = imem_rsp_valid && !redirect_valid && (r_drop == '0);
  assign w_pop          = instr_valid && instr_ready && !redirect_valid;

  assign w_push_entry.instr = imem_rsp_data;
  assign w_push_entry.pc    = r_rsp_pc;

  assign instr_valid    = !w_fifo_empty;
  assign instr          = w_head.instr;
  assign instr_pc       = w_head.pc;
  assign instr_pc_plus4 = w_head.pc + XLEN'(4);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Next outstanding/drop counts; a redirect re-derives drop from what remains in flight.
  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_req_fire)     w_outstanding_next = w_outstanding_next + CNT_W'(1);
    if (imem_rsp_valid) w_outstanding_next = w_outstanding_next - CNT_W'(1);

    w_drop_next = r_drop;
    if (redirect_valid) begin
      w_drop_next = w_outstanding_next;
    end else if (imem_rsp_valid && (r_drop != '0)) begin
      w_drop_next = r_drop - CNT_W'(1);
    end
  end

  // Fetch/response PC tracking and in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_drop        <= w_drop_next;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push)     r_rsp_pc   <= r_rsp_pc + XLEN'(4);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;

  // Count kept and discarded responses; both wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
    end else begin
      if (w_push)  r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_stale) r_perf_dropped <= r_perf_dropped + 32'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = w_stale ^ w_fifo_full;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a small in-order memory model of
// configurable latency. Optional macro FETCH_PERF_EN enables counter checks.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  int n_acc    = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present due response, log request handshake, cross the edge.
  task automatic tick();
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
      n_acc++;
      $display("cycle %0d: request addr %h accepted", cyc, imem_req_addr);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic release_reset();
    pend_addr.delete();
    pend_due.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    #1;
    rst   = 1'b1;
    #1;
    cyc   = 0;
    n_acc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    release_reset();
  endtask

  initial begin
    bit found;
    rst            = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    lat            = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    release_reset();

    // 1-cycle memory, decode always ready
    chk("a_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("a_first_req_addr", imem_req_addr, 32'h0);
    tick();
    chk("a_c1_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("a_c1_req_addr", imem_req_addr, 32'h4);
    tick();
    chk("a_c2_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("a_c2_pc", instr_pc, 32'h0);
    chk("a_c2_pc4", instr_pc_plus4, 32'h4);
    chk("a_c2_instr", instr, mem_word(32'h0));
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("a_stream_valid", {31'd0, instr_valid}, 32'd1);
      chk("a_stream_pc", instr_pc, 32'(k * 4));
      chk("a_stream_instr", instr, mem_word(32'(k * 4)));
    end

    // Reset mid-stream
    rst = 1'b0;
    #1;
    chk("r_async_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("r_async_req_valid", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    release_reset();
    chk("r_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("r_req_addr", imem_req_addr, 32'h0);

    // Decode stalled: credit limit of 4
    do_reset();
    instr_ready = 1'b0;
    repeat (8) tick();
    chk("b_accepted", 32'(n_acc), 32'd4);
    chk("b_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("b_instr_valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("b_drain_pc", instr_pc, 32'(k * 4));
      chk("b_drain_instr", instr, mem_word(32'(k * 4)));
      tick();
    end

    // 3-cycle memory, redirect with 2 requests in flight
    lat = 3;
    do_reset();
    tick();
    tick();
    chk("c_in_flight", 32'(n_acc), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    chk("c_redirect_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("c_n1_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("c_n1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("c_n1_req_addr", imem_req_addr, 32'h0000_0100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      found = instr_valid;
    end
    chk("c_wait_valid", {31'd0, found}, 32'd1);
    chk("c_first_pc", instr_pc, 32'h0000_0100);
    chk("c_first_instr", instr, mem_word(32'h0000_0100));
`ifdef FETCH_PERF_EN
    chk("c_perf_dropped", perf_dropped, 32'd2);
    chk("c_perf_fetched", perf_fetched, 32'd1);
`endif

    // Redirect coinciding with a pop and a response
    lat = 1;
    do_reset();
    tick();
    tick();
    chk("d_pre_pc", instr_pc, 32'h0);
    chk("d_pre_valid", {31'd0, instr_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("d_n1_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("d_n1_req_addr", imem_req_addr, 32'h0000_0200);
    chk("d_n1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    tick();
    tick();
    chk("d_new_valid", {31'd0, instr_valid}, 32'd1);
    chk("d_new_pc", instr_pc, 32'h0000_0200);

    // Redirect to an unaligned address near the top of memory
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    #1;
    chk("e_redirect_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("e_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("e_req_addr1", imem_req_addr, 32'h0000_0000);
    tick();
    chk("e_valid", {31'd0, instr_valid}, 32'd1);
    chk("e_pc", instr_pc, 32'hFFFF_FFFC);
    chk("e_pc4", instr_pc_plus4, 32'h0000_0000);
    tick();
    chk("e_wrap_pc", instr_pc, 32'h0000_0000);
    chk("e_wrap_pc4", instr_pc_plus4, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
